dfr_pipe: RTL and testbench

Parametrised successor to the single-bit D-flipflop stand-in: a WIDTH-bit, DEPTH-stage elastic register pipeline with per-stage valid bits, valid/ready flow control and bubble collapsing. It is used wherever the digital core needs retiming stages that can also absorb back-pressure, such as register-to-pad paths and clock-domain-local buffering ahead of peripherals. Behaviour is cycle-exact so it can stand in for a synthesized netlist built from XH018 DFF cells.

---
 rtl/dcells_pkg.sv | 12 +
 rtl/dfr_stage.sv | 47 ++++
 rtl/dfr_pipe.sv | 83 ++++++++
 tb/tb_dfr_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dcells_pkg.sv
// dcells_pkg: shared constants and helpers for the DFF-cell replacement blocks.
//   DATA_RST_BIT : value every data bit takes in reset
//   cnt_width()  : width of an occupancy counter able to hold 0..depth
package dcells_pkg;

  localparam bit DATA_RST_BIT = 1'b0;

  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dfr_stage.sv
// dfr_stage: one elastic pipeline register (data + valid) with hold/load.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ld              : stage may take new contents this edge (its ready)
//   v_in, d_in      : incoming valid / data from the upstream stage
//   v_out, d_out    : registered valid / data
module dfr_stage
  import dcells_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Data only moves when a valid item arrives; an incoming bubble clears
  // the valid bit but leaves the data bits quiet.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (ld) begin
      v_d = v_in;
      if (v_in) data_d = d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      data_q <= {WIDTH{DATA_RST_BIT}};
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign v_out = v_q;
  assign d_out = data_q;

endmodule

// File: rtl/dfr_pipe.sv
// dfr_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline with valid/ready
// flow control and bubble collapsing.
//   C, RN     : clock (rising edge), asynchronous active-low reset
//   D, DV, DR : upstream data / valid / ready (DR combinational from QR, v[])
//   Q, QV, QR : downstream data / valid (registered) / ready
//   CNT       : number of occupied stages, 0..DEPTH
//   QN        : ~Q, present only when DFR_PIPE_QN_EN is defined
module dfr_pipe
  import dcells_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                            C,
  input  logic                            RN,
  input  logic [WIDTH-1:0]                D,
  input  logic                            DV,
  output logic                            DR,
  output logic [WIDTH-1:0]                Q,
  output logic                            QV,
  input  logic                            QR,
  output logic [cnt_width(DEPTH)-1:0]     CNT
`ifdef DFR_PIPE_QN_EN
  ,
  output logic [WIDTH-1:0]                QN
`endif
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH:0]                rdy;
  logic [DEPTH-1:0]              v;
  logic [DEPTH-1:0][WIDTH-1:0]   data;
  logic [DEPTH-1:0]              v_in;
  logic [DEPTH-1:0][WIDTH-1:0]   d_in;
  logic [CW-1:0]                 cnt;

  // Stage i is fed from stage i-1; stage 0 from the upstream port.
  always_comb begin
    v_in[0] = DV;
    d_in[0] = D;
    for (int i = 1; i < DEPTH; i++) begin
      v_in[i] = v[i-1];
      d_in[i] = data[i-1];
    end
  end

  // A stage can load if it is empty or its successor is loading this edge,
  // so an item slides into a hole even while the output is stalled.
  always_comb begin
    rdy[DEPTH] = QR;
    for (int i = DEPTH - 1; i >= 0; i--)
      rdy[i] = ~v[i] | rdy[i+1];
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    dfr_stage #(.WIDTH(WIDTH)) u_stg (
      .clk   (C),
      .rst_n (RN),
      .ld    (rdy[g]),
      .v_in  (v_in[g]),
      .d_in  (d_in[g]),
      .v_out (v[g]),
      .d_out (data[g])
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt = cnt + CW'(v[i]);
  end

  assign DR  = rdy[0];
  assign Q   = data[DEPTH-1];
  assign QV  = v[DEPTH-1];
  assign CNT = cnt;

`ifdef DFR_PIPE_QN_EN
  assign QN  = ~data[DEPTH-1];
`endif

endmodule

// File: tb/tb_dfr_pipe.sv
module tb_dfr_pipe;

  logic C = 1'b0;
  logic RN;
  always #5 C = ~C;

  // DEPTH=2, WIDTH=8
  logic [7:0] D2, Q2;  logic DV2, DR2, QV2, QR2;  logic [1:0] CNT2;
  // DEPTH=4, WIDTH=8
  logic [7:0] D4, Q4;  logic DV4, DR4, QV4, QR4;  logic [2:0] CNT4;
  // DEPTH=1, WIDTH=1
  logic       D1, Q1;  logic DV1, DR1, QV1, QR1;  logic       CNT1;
`ifdef DFR_PIPE_QN_EN
  logic [7:0] QN2, QN4;  logic QN1;
`endif

  dfr_pipe #(.WIDTH(8), .DEPTH(2)) u2 (
    .C(C), .RN(RN), .D(D2), .DV(DV2), .DR(DR2), .Q(Q2), .QV(QV2), .QR(QR2), .CNT(CNT2)
`ifdef DFR_PIPE_QN_EN
    , .QN(QN2)
`endif
  );
  dfr_pipe #(.WIDTH(8), .DEPTH(4)) u4 (
    .C(C), .RN(RN), .D(D4), .DV(DV4), .DR(DR4), .Q(Q4), .QV(QV4), .QR(QR4), .CNT(CNT4)
`ifdef DFR_PIPE_QN_EN
    , .QN(QN4)
`endif
  );
  dfr_pipe #(.WIDTH(1), .DEPTH(1)) u1 (
    .C(C), .RN(RN), .D(D1), .DV(DV1), .DR(DR1), .Q(Q1), .QV(QV1), .QR(QR1), .CNT(CNT1)
`ifdef DFR_PIPE_QN_EN
    , .QN(QN1)
`endif
  );

  int errs = 0;
  int checks = 0;
  logic [7:0] sb2[$], sb4[$];
  logic       sb1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_fail(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: output with empty scoreboard", nm);
  endtask

  // Scoreboard monitor: outputs are compared before this edge's pushes are
  // recorded, since a push seen now cannot reach Q before the next edge.
  always @(negedge C) begin
    if (RN) begin
      if (QV2 && QR2) begin
        if (sb2.size() == 0) pop_fail("sb2"); else chk("sb2_q", 32'(Q2), 32'(sb2.pop_front()));
      end
      if (QV4 && QR4) begin
        if (sb4.size() == 0) pop_fail("sb4"); else chk("sb4_q", 32'(Q4), 32'(sb4.pop_front()));
      end
      if (QV1 && QR1) begin
        if (sb1.size() == 0) pop_fail("sb1"); else chk("sb1_q", 32'(Q1), 32'(sb1.pop_front()));
      end
      if (DV2 && DR2) sb2.push_back(D2);
      if (DV4 && DR4) sb4.push_back(D4);
      if (DV1 && DR1) sb1.push_back(D1);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge C);
    #1;
  endtask

  initial begin
    RN = 1'b0;
    D2 = 8'hA5; DV2 = 1'b1; QR2 = 1'b1;
    D4 = 8'hA5; DV4 = 1'b1; QR4 = 1'b1;
    D1 = 1'b1;  DV1 = 1'b0; QR1 = 1'b1;
    #2;
    // Reset with traffic presented
    chk("rst_q2", 32'(Q2), 0);     chk("rst_qv2", 32'(QV2), 0);
    chk("rst_cnt2", 32'(CNT2), 0); chk("rst_dr2", 32'(DR2), 1);
    chk("rst_cnt4", 32'(CNT4), 0); chk("rst_qv1", 32'(QV1), 0);
`ifdef DFR_PIPE_QN_EN
    chk("rst_qn2", 32'(QN2), 'hFF); chk("rst_qn1", 32'(QN1), 1);
`endif
    step();
    chk("rst_hold_qv2", 32'(QV2), 0);
    DV2 = 1'b0; DV4 = 1'b0;
    RN = 1'b1;
    step(); step();
    chk("post_rst_qv2", 32'(QV2), 0);
    chk("post_rst_cnt2", 32'(CNT2), 0);

    // Streaming DEPTH=2: 01..10 back-to-back, output from 2nd edge, no gaps
    for (int i = 1; i <= 16; i++) begin
      D2 = 8'(i); DV2 = 1'b1;
      step();
      if (i == 1) chk("lat_qv2_early", 32'(QV2), 0);
      else begin
        chk("stream_qv2", 32'(QV2), 1);
        chk("stream_q2", 32'(Q2), 32'(i - 1));
      end
    end
    DV2 = 1'b0;
    step();
    chk("stream_last_q2", 32'(Q2), 'h10); chk("stream_last_qv2", 32'(QV2), 1);
    step();
    chk("empty_qv2", 32'(QV2), 0); chk("empty_hold_q2", 32'(Q2), 'h10);

    // Back-pressure DEPTH=2
    QR2 = 1'b0; D2 = 8'h21; DV2 = 1'b1;
    step();
    D2 = 8'h22;
    step();
    chk("bp_cnt2", 32'(CNT2), 2); chk("bp_dr2", 32'(DR2), 0);
    chk("bp_q2", 32'(Q2), 'h21);  chk("bp_qv2", 32'(QV2), 1);
    D2 = 8'h23;
    step();
    chk("bp_hold_cnt2", 32'(CNT2), 2); chk("bp_hold_q2", 32'(Q2), 'h21);
    QR2 = 1'b1;
    #1 chk("bp_dr2_comb", 32'(DR2), 1);
    step();
    chk("bp_swap_cnt2", 32'(CNT2), 2); chk("bp_swap_q2", 32'(Q2), 'h22);
    DV2 = 1'b0;
    step(); step(); step();
    chk("bp_drain_cnt2", 32'(CNT2), 0);

    // Bubble collapse DEPTH=4 with QR=0
    QR4 = 1'b0; D4 = 8'h5A; DV4 = 1'b1;
    chk("bub_dr4_pre", 32'(DR4), 1);
    for (int e = 1; e <= 4; e++) begin
      step();
      DV4 = 1'b0;
      chk("bub_dr4", 32'(DR4), 1);
      chk("bub_cnt4", 32'(CNT4), 1);
      chk("bub_qv4", 32'(QV4), (e == 4) ? 1 : 0);
    end
    chk("bub_q4", 32'(Q4), 'h5A);

    // Build CNT=3, then reset between edges
    D4 = 8'h5B; DV4 = 1'b1;
    step();
    D4 = 8'h5C;
    step();
    DV4 = 1'b0;
    chk("mid_cnt4", 32'(CNT4), 3); chk("mid_dr4", 32'(DR4), 1);
    #1 RN = 1'b0;
    #1;
    chk("mid_rst_qv4", 32'(QV4), 0); chk("mid_rst_cnt4", 32'(CNT4), 0);
    chk("mid_rst_q4", 32'(Q4), 0);   chk("mid_rst_dr4", 32'(DR4), 1);
    sb2.delete(); sb4.delete(); sb1.delete();
    RN = 1'b1;
    QR4 = 1'b1;
    step();
    chk("mid_after_qv4", 32'(QV4), 0);
    for (int i = 0; i < 3; i++) begin
      D4 = 8'h61 + 8'(i); DV4 = 1'b1;
      step();
    end
    DV4 = 1'b0;
    step();
    chk("lat4_q4", 32'(Q4), 'h61); chk("lat4_qv4", 32'(QV4), 1);
    step(); step(); step();
    chk("mid_drain_cnt4", 32'(CNT4), 0);

    // DEPTH=1, WIDTH=1
    QR1 = 1'b0; D1 = 1'b1; DV1 = 1'b1;
    step();
    chk("d1_q1", 32'(Q1), 1);   chk("d1_qv1", 32'(QV1), 1);
    chk("d1_cnt1", 32'(CNT1), 1); chk("d1_dr1_full", 32'(DR1), 0);
`ifdef DFR_PIPE_QN_EN
    chk("d1_qn1", 32'(QN1), 0);
`endif
    QR1 = 1'b1;
    #1 chk("d1_dr1_pop", 32'(DR1), 1);
    begin
      logic [3:0] pat;
      pat = 4'b0110;
      for (int i = 0; i < 4; i++) begin
        D1 = pat[i];
        step();
        chk("d1_swap_qv1", 32'(QV1), 1);
        chk("d1_swap_q1", 32'(Q1), 32'(pat[i]));
        chk("d1_swap_cnt1", 32'(CNT1), 1);
      end
    end
    DV1 = 1'b0;
    step();
    chk("d1_empty_qv1", 32'(QV1), 0); chk("d1_empty_cnt1", 32'(CNT1), 0);
    step();

    chk("sb2_drained", 32'(sb2.size()), 0);
    chk("sb4_drained", 32'(sb4.size()), 0);
    chk("sb1_drained", 32'(sb1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
